// File: rtl/prog_loader.sv
// Framed byte-stream loader: assembles big-endian words into main RAM and holds the core in reset until the checksum passes.
// Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int unsigned addWidth = 8,
  parameter logic [7:0]  MAGIC    = 8'hA5,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          byteIn,
  input  logic                byteValid,
  output logic                byteReady,
  output logic                wEnable,
  output logic [addWidth-1:0] WSelect,
  output logic [31:0]         writeDB,
  output logic                cpuRst,
  output logic                done,
  output logic                err,
  output logic [8:0]          wordCount
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE} state_t;

  state_t              state_q;
  logic [8:0]          n_q;
  logic [1:0]          idx_q;
  logic [23:0]         asm_q;
  logic [7:0]          csum_q;
  logic                we_q;
  logic [addWidth-1:0] wsel_q;
  logic [31:0]         wdat_q;
  logic                cpu_rst_q;
  logic                done_q;
  logic                err_q;
  logic [8:0]          wcnt_q;

  logic                accept_d;
  logic [8:0]          wcnt_d;
  logic                tmo_hit_d;

  assign byteReady = (state_q != WRITE);
  assign accept_d  = byteValid & byteReady;
  assign wcnt_d    = wcnt_q + 9'd1;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_run_d;

  assign tmo_run_d = ((state_q == LEN) || (state_q == DATA) || (state_q == CSUM)) && !accept_d;
  // Hit on the idle cycle that brings the count up to TIMEOUT.
  assign tmo_hit_d = tmo_run_d && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (accept_d) begin
      tmo_q <= '0;
    end else if (tmo_run_d) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  logic unused_timeout;
  assign tmo_hit_d      = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      asm_q     <= '0;
      csum_q    <= '0;
      we_q      <= 1'b0;
      wsel_q    <= '0;
      wdat_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (tmo_hit_d) begin
        state_q   <= IDLE;
        err_q     <= 1'b1;
        cpu_rst_q <= 1'b1;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (accept_d && byteIn == MAGIC) begin
              state_q   <= LEN;
              err_q     <= 1'b0;
              wcnt_q    <= '0;
              wsel_q    <= '0;
              csum_q    <= '0;
              cpu_rst_q <= 1'b1;
              done_q    <= 1'b0;
            end
          end
          LEN: begin
            if (accept_d) begin
              n_q     <= (byteIn == 8'd0) ? 9'd256 : {1'b0, byteIn};
              idx_q   <= '0;
              state_q <= DATA;
            end
          end
          DATA: begin
            if (accept_d) begin
              asm_q  <= {asm_q[15:0], byteIn};
              csum_q <= csum_q ^ byteIn;
              idx_q  <= idx_q + 2'd1;
              if (idx_q == 2'd3) begin
                we_q    <= 1'b1;
                wdat_q  <= {asm_q, byteIn};
                state_q <= WRITE;
              end
            end
          end
          WRITE: begin
            wsel_q  <= wsel_q + addWidth'(1);
            wcnt_q  <= wcnt_d;
            state_q <= (wcnt_d == n_q) ? CSUM : DATA;
          end
          CSUM: begin
            if (accept_d) begin
              if (byteIn == csum_q) begin
                state_q   <= DONE;
                done_q    <= 1'b1;
                cpu_rst_q <= 1'b0;
              end else begin
                state_q   <= IDLE;
                err_q     <= 1'b1;
                done_q    <= 1'b0;
                cpu_rst_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wEnable   = we_q;
  assign WSelect   = wsel_q;
  assign writeDB   = wdat_q;
  assign cpuRst    = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wordCount = wcnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames from the test plan plus randomized frames against a frame-level reference model.
module tb_prog_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    byteIn = 8'h00;
  logic          byteValid = 1'b0;
  logic          byteReady;
  logic          wEnable;
  logic [AW-1:0] WSelect;
  logic [31:0]   writeDB;
  logic          cpuRst;
  logic          done;
  logic          err;
  logic [8:0]    wordCount;

  prog_loader #(.addWidth(AW), .MAGIC(8'hA5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
    .wEnable(wEnable), .WSelect(WSelect), .writeDB(writeDB), .cpuRst(cpuRst),
    .done(done), .err(err), .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [AW+31:0] exp_q[$];
  logic [7:0]     fdata[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  // Every write pulse must match the next expected (address, word) pair.
  always @(negedge clk) begin
    if (rst && wEnable !== 1'b0) begin
      check("rdy_in_write", 32'(byteReady), 32'd0);
      check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(WSelect), 32'(e[AW+31:32]));
        check("wr_data", writeDB, e[31:0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_gap(input int gap);
    if (gap >= 0) idle(gap);
    else idle($urandom_range(-gap, 0));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    byteIn = b;
    byteValid = 1'b1;
    while (byteReady !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) check("ready_timeout", 32'(byteReady), 32'd1);
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) fdata.push_back(w[8*i +: 8]);
  endtask

  function automatic logic [7:0] xor_data();
    logic [7:0] x;
    x = 8'h00;
    foreach (fdata[i]) x ^= fdata[i];
    return x;
  endfunction

  // Sends MAGIC, len_b, fdata, csum_b and checks the frame-level outcome.
  task automatic send_frame(input logic [7:0] len_b, input logic [7:0] csum_b, input int gap);
    int   n;
    bit   good;
    n    = (len_b == 8'd0) ? 256 : int'(len_b);
    good = (csum_b == xor_data());
    for (int k = 0; k < n; k++)
      exp_q.push_back({AW'(k % (1 << AW)), fdata[4*k], fdata[4*k+1], fdata[4*k+2], fdata[4*k+3]});
    send_byte(8'hA5);
    check("start_err", 32'(err), 32'd0);
    check("start_done", 32'(done), 32'd0);
    check("start_cpurst", 32'(cpuRst), 32'd1);
    check("start_wsel", 32'(WSelect), 32'd0);
    check("start_wcnt", 32'(wordCount), 32'd0);
    send_byte(len_b);
    for (int i = 0; i < 4*n; i++) begin
      do_gap(gap);
      send_byte(fdata[i]);
      if (i % 4 == 3) check("we_latency", 32'(wEnable), 32'd1);
    end
    do_gap(gap);
    check("pre_cpurst", 32'(cpuRst), 32'd1);
    check("pre_done", 32'(done), 32'd0);
    send_byte(csum_b);
    check("end_done", 32'(done), 32'(good));
    check("end_cpurst", 32'(cpuRst), 32'(!good));
    check("end_err", 32'(err), 32'(!good));
    check("end_wcnt", 32'(wordCount), 32'(n));
    check("end_writes_left", 32'(exp_q.size()), 32'd0);
    fdata.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    idle(3);
    check("rst_cpurst", 32'(cpuRst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_we", 32'(wEnable), 32'd0);
    check("rst_wsel", 32'(WSelect), 32'd0);
    check("rst_wdat", writeDB, 32'd0);
    check("rst_wcnt", 32'(wordCount), 32'd0);
    check("rst_rdy", 32'(byteReady), 32'd1);
    rst = 1'b1;
    idle(2);

    // Single word
    push_word(32'hDEADBEEF);
    send_frame(8'h01, 8'h22, 0);
    idle(3);
    check("hold_wdat", writeDB, 32'hDEADBEEF);
    check("hold_done", 32'(done), 32'd1);

    // Bad checksum, then recovery
    push_word(32'hDEADBEEF);
    send_frame(8'h01, 8'h23, 0);
    push_word(32'hDEADBEEF);
    send_frame(8'h01, 8'h22, 0);

    // Two words, valid toggled every other cycle
    push_word(32'h00000001);
    push_word(32'h00000002);
    send_frame(8'h02, 8'h03, 1);

    // Noise is ignored in DONE; MAGIC restarts from address 0
    send_byte(8'h00);
    send_byte(8'hFF);
    check("noise_done", 32'(done), 32'd1);
    check("noise_cpurst", 32'(cpuRst), 32'd0);
    push_word($urandom);
    send_frame(8'h01, xor_data(), 0);

    // Reset mid-word
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst = 1'b0;
    #1;
    check("mid_cpurst", 32'(cpuRst), 32'd1);
    check("mid_done", 32'(done), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_we", 32'(wEnable), 32'd0);
    check("mid_wsel", 32'(WSelect), 32'd0);
    check("mid_wdat", writeDB, 32'd0);
    check("mid_wcnt", 32'(wordCount), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(1);
    push_word(32'hDEADBEEF);
    send_frame(8'h01, 8'h22, 0);

    // Stalled stream
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hDE);
    idle(20);
`ifdef LOADER_TIMEOUT_EN
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_cpurst", 32'(cpuRst), 32'd1);
    check("tmo_done", 32'(done), 32'd0);
    push_word(32'h12345678);
    send_frame(8'h01, xor_data(), 0);
`else
    check("stall_err", 32'(err), 32'd0);
    check("stall_done", 32'(done), 32'd0);
    exp_q.push_back({AW'(0), 32'hDEADBEEF});
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    idle(1);
    send_byte(8'h22);
    check("stall_resume_done", 32'(done), 32'd1);
    check("stall_resume_err", 32'(err), 32'd0);
`endif

    // Randomized frames, one with L = 0 (256 words)
    for (int f = 0; f < 10; f++) begin
      logic [7:0] len_b;
      logic [7:0] flip;
      int         n;
      len_b = (f == 5) ? 8'd0 : 8'($urandom_range(1, 6));
      n     = (len_b == 8'd0) ? 256 : int'(len_b);
      for (int k = 0; k < n; k++) push_word($urandom);
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] nb;
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h00;
        send_byte(nb);
      end
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(len_b, xor_data() ^ flip, -2);
    end

    idle(4);
    check("final_writes_left", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
